// File: rtl/grf_dumper_pkg.sv
// Shared definitions for the GRF debug read-out engine.
//   REG_CNT / REG_AW / DATA_W : register file geometry
//   dump_state_t              : dumper FSM states
package grf_pkg;

    localparam int REG_CNT = 32;
    localparam int REG_AW  = 5;
    localparam int DATA_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } dump_state_t;

endpackage

// File: rtl/grf_dumper.sv
// GRF debug read-out engine. On start, walks registers 0..31 through a
// spare combinational GRF read port and streams (address, value) beats
// over a valid/ready interface through a one-entry output buffer.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      begin dump (sampled only in IDLE)
//   busy       high while RUN or DRAIN
//   done       one-cycle pulse after the dump completes
//   rd_addr    GRF read-port address
//   rd_data    GRF read-port data (same cycle)
//   out_valid  output beat valid
//   out_ready  consumer accepts the beat
//   out_addr   register index of the beat
//   out_data   register value of the beat
module grf_dumper
    import grf_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [REG_AW-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    localparam int IDX_W = REG_AW + 1;

    dump_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic              vld_q,   vld_d;
    logic [REG_AW-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              done_q,  done_d;

    logic slot_free;
    logic handshake;
    logic skip;
    logic capture;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        vld_d     = vld_q;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = 1'b0;
        rd_addr   = '0;
        skip      = 1'b0;
        capture   = 1'b0;
        slot_free = !vld_q || out_ready;
        handshake = vld_q && out_ready;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                end
            end
            RUN: begin
                rd_addr = idx_q[REG_AW-1:0];
                // Zero values are dropped even while the buffer is stalled,
                // so skipping never waits on the consumer.
                skip = SKIP_ZERO && (rd_data == '0);
                if (skip || slot_free) begin
                    capture = !skip;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(REG_CNT - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!vld_q || out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A capture refills the slot in the same cycle it is drained.
        if (capture) begin
            vld_d  = 1'b1;
            addr_d = idx_q[REG_AW-1:0];
            data_d = rd_data;
        end else if (handshake) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign out_valid = vld_q;
    assign out_addr  = addr_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_grf_dumper.sv
// Self-checking bench for grf_dumper: one instance with SKIP_ZERO=0 and one
// with SKIP_ZERO=1 share the stimulus and a behavioural GRF model.
module tb_grf_dumper;

    logic        clk;
    logic        rst;
    logic        start;
    logic        ready;
    logic [31:0] grf [32];
    logic [31:0] cap [32];

    logic        busy0, done0, v0, busy1, done1, v1;
    logic [4:0]  ra0, a0, ra1, a1;
    logic [31:0] rd0, d0, rd1, d1;

    int cyc;
    int tests;
    int fails;

    logic [36:0] q0[$], q1[$], exp0[$], exp1[$];
    int          c0q[$];
    int          dn0, dn1, dcyc0, dcyc1;

    assign rd0 = (ra0 == 5'd0) ? 32'd0 : grf[ra0];
    assign rd1 = (ra1 == 5'd0) ? 32'd0 : grf[ra1];

    grf_dumper #(.SKIP_ZERO(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
        .rd_addr(ra0), .rd_data(rd0), .out_valid(v0), .out_ready(ready),
        .out_addr(a0), .out_data(d0)
    );

    grf_dumper #(.SKIP_ZERO(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
        .rd_addr(ra1), .rd_data(rd1), .out_valid(v1), .out_ready(ready),
        .out_addr(a1), .out_data(d1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Beat and done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (v0 && ready) begin
                q0.push_back({a0, d0});
                c0q.push_back(cyc);
            end
            if (v1 && ready) q1.push_back({a1, d1});
            if (done0) begin dn0 = dn0 + 1; dcyc0 = cyc; end
            if (done1) begin dn1 = dn1 + 1; dcyc1 = cyc; end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests = tests + 1;
        assert (obs === exp)
        else begin
            fails = fails + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cycle(int c);
        while (cyc < c) tick();
        @(negedge clk);
    endtask

    task automatic clear_mon();
        q0.delete(); q1.delete(); c0q.delete();
        dn0 = 0; dn1 = 0; dcyc0 = -1; dcyc1 = -1;
    endtask

    // Expected streams from capture-time register values.
    task automatic build_exp();
        logic [31:0] v;
        exp0.delete(); exp1.delete();
        for (int k = 0; k < 32; k++) begin
            v = (k == 0) ? 32'd0 : cap[k];
            exp0.push_back({5'(k), v});
            if (v != 32'd0) exp1.push_back({5'(k), v});
        end
    endtask

    task automatic compare_streams(string tag);
        check({tag, "_n0"}, q0.size(), exp0.size());
        check({tag, "_n1"}, q1.size(), exp1.size());
        for (int i = 0; i < q0.size() && i < exp0.size(); i++)
            check({tag, "_b0"}, q0[i], exp0[i]);
        for (int i = 0; i < q1.size() && i < exp1.size(); i++)
            check({tag, "_b1"}, q1[i], exp1[i]);
    endtask

    task automatic do_start(output int cs);
        clear_mon();
        start = 1'b1;
        tick();
        cs = cyc;
        start = 1'b0;
    endtask

    initial begin
        int cs;
        cyc = 0; tests = 0; fails = 0;
        rst = 1'b0; start = 1'b0; ready = 1'b1;
        clear_mon();
        for (int k = 0; k < 32; k++) grf[k] = 32'h1000_0000 + 32'(k);

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("reset_outs0", {busy0, done0, v0, a0, d0, ra0}, '0);
        check("reset_outs1", {busy1, done1, v1, a1, d1, ra1}, '0);
        tick();
        rst = 1'b1;
        repeat (2) tick();

        // Full dump with ready held high
        cap = grf;
        build_exp();
        do_start(cs);
        at_cycle(cs);
        check("busy_first", busy0, 1'b1);
        at_cycle(cs + 32);
        check("busy_last", busy0, 1'b1);
        at_cycle(cs + 33);
        check("busy_after", busy0, 1'b0);
        check("idle_rdaddr", ra0, 5'd0);
        at_cycle(cs + 36);
        compare_streams("basic");
        for (int k = 0; k < c0q.size(); k++) check("beat_cyc", c0q[k], cs + 1 + k);
        check("basic_dn0", dn0, 1);
        check("basic_dn1", dn1, 1);
        check("basic_dcyc0", dcyc0, cs + 33);
        check("basic_dcyc1", dcyc1, cs + 33);

        // Stall at beat 7 for 5 cycles
        cap = grf;
        build_exp();
        do_start(cs);
        while (cyc < cs + 8) tick();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold0", {v0, a0, d0}, {1'b1, 5'd7, grf[7]});
            check("stall_hold1", {v1, a1, d1}, {1'b1, 5'd7, grf[7]});
            tick();
        end
        ready = 1'b1;
        at_cycle(cs + 41);
        compare_streams("stall");
        check("stall_dn0", dn0, 1);
        check("stall_dcyc0", dcyc0, cs + 38);
        check("stall_dcyc1", dcyc1, cs + 38);

        // Sparse register file
        for (int k = 0; k < 32; k++) grf[k] = 32'd0;
        grf[3]  = 32'h0000_DEAD;
        grf[29] = 32'h0000_2FFC;
        cap = grf;
        build_exp();
        do_start(cs);
        at_cycle(cs + 36);
        compare_streams("sparse");
        check("sparse_n1", q1.size(), 2);
        check("sparse_dcyc1", dcyc1, cs + 33);
        check("sparse_dn1", dn1, 1);

        // Snapshot: write $5 after capture and $6 before capture
        for (int k = 0; k < 32; k++) grf[k] = 32'h1000_0000 + 32'(k);
        cap = grf;
        cap[6] = 32'hABCD_0006;
        build_exp();
        do_start(cs);
        while (cyc < cs + 6) tick();
        grf[5] = 32'h5555_5555;
        grf[6] = 32'hABCD_0006;
        at_cycle(cs + 36);
        compare_streams("snap");

        // Randomised register contents and back-pressure
        for (int r = 0; r < 4; r++) begin
            int lim;
            for (int k = 0; k < 32; k++)
                grf[k] = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            cap = grf;
            build_exp();
            do_start(cs);
            lim = cs + 600;
            while ((dn0 == 0 || dn1 == 0) && cyc < lim) begin
                ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            ready = 1'b1;
            repeat (3) tick();
            check("rand_dn0", dn0, 1);
            check("rand_dn1", dn1, 1);
            compare_streams("rand");
        end

        // start while busy has no effect
        for (int k = 0; k < 32; k++) grf[k] = 32'h2000_0000 + 32'(k * 3);
        cap = grf;
        build_exp();
        do_start(cs);
        while (cyc < cs + 10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        at_cycle(cs + 40);
        compare_streams("rebusy");
        check("rebusy_dn0", dn0, 1);
        check("rebusy_dcyc0", dcyc0, cs + 33);

        // Reset mid-dump, then a fresh dump
        do_start(cs);
        while (cyc < cs + 12) tick();
        #2;
        rst = 1'b0;
        #1;
        check("midrst_outs0", {busy0, done0, v0, a0, d0, ra0}, '0);
        check("midrst_outs1", {busy1, done1, v1, a1, d1, ra1}, '0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (40) tick();
        check("midrst_nodone0", dn0, 0);
        check("midrst_nodone1", dn1, 0);
        do_start(cs);
        at_cycle(cs + 36);
        compare_streams("restart");
        check("restart_dcyc0", dcyc0, cs + 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/grf_dumper.md
# grf_dumper

Debug read-out engine for the general register file. On a `start` pulse it walks registers 0–31 through one spare GRF read port and streams each (address, value) pair out over a valid/ready interface. The bench uses it to compare architectural state against the reference model at end of test, and the CPU top uses it for a debug state dump. It is the reader counterpart of the GRF write path and never writes the register file.

## Interface
Parameters:
- `SKIP_ZERO`, default 0: when 1, registers whose read value is 0 are not emitted.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin dump; sampled only in IDLE
- `busy`  out  1  high while state is RUN or DRAIN
- `done`  out  1  one-cycle pulse after the dump completes
- `rd_addr`  out  5  to GRF read-port address
- `rd_data`  in  32  from GRF read port; combinational, same cycle
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  consumer accepts the beat
- `out_addr`  out  5  register index of the beat
- `out_data`  out  32  register value of the beat

## Operation
- Internal state:
  - 6-bit index `idx` (0–32)
  - one-entry output buffer (`out_valid`, `out_addr`, `out_data`)
  - FSM with states IDLE, RUN, DRAIN.
- IDLE:
  - `rd_addr`=0.
  - `start`=1 → RUN with `idx`=0.
  - `start` is ignored in RUN and DRAIN.
- RUN:
  - `rd_addr`=`idx[4:0]`.
  - The slot is free when `!out_valid || out_ready`.
  - Emit case: slot free and (`SKIP_ZERO`=0 or `rd_data`≠0). Capture {`idx`, `rd_data`} into the buffer and increment `idx`.
  - Skip case: `SKIP_ZERO`=1 and `rd_data`==0. Increment `idx` without capturing, even while the buffer is stalled.
  - Otherwise (stalled, not skipping): hold `idx` and `rd_addr`.
  - When `idx` advances past 31 → DRAIN.
- DRAIN:
  - No further reads; `rd_addr`=0.
  - Buffer empty, or a handshake this cycle → IDLE, with `done` asserted the next cycle.
- Buffer:
  - A handshake is `out_valid && out_ready`.
  - On a handshake with no new capture, `out_valid` clears.
  - While `out_valid`=1 and `out_ready`=0, `out_addr` and `out_data` hold stable.
- Snapshot semantics:
  - A value is the GRF content at its capture cycle.
  - Writes to an already-captured register are not reflected.
- Register 0 reads 0, so with `SKIP_ZERO`=1 it is never emitted.

## Timing
- Reset (asynchronous, `rst`=0):
  - state IDLE, `idx`=0
  - `busy`=0, `done`=0, `out_valid`=0, `out_addr`=0, `out_data`=0, `rd_addr`=0.
  - Reset mid-dump aborts immediately with no `done`; the partial stream is discarded.
- Dump with `start` sampled at edge T and `out_ready` held 1:
  - RUN in cycles T+1…T+32.
  - Beats for addresses 0…31 in cycles T+2…T+33.
  - DRAIN in T+33; `done`=1 in T+34 only.
  - `busy`=1 in T+1…T+33.
- Throughput: one beat per cycle while `out_ready`=1; no bubble after a stall is released.
- Latency: GRF read in cycle N → `out_valid` in cycle N+1.
- `start` asserted in the same cycle as `done` starts a new dump, since the state is IDLE.
- `SKIP_ZERO`=1 with all registers 0:
  - 32 RUN cycles, then DRAIN for 1 cycle, then `done`.
  - No beats.

## Structure
- Package `grf_pkg`:
  - `REG_CNT`=32, `REG_AW`=5, `DATA_W`=32
  - enum `dump_state_t` {IDLE, RUN, DRAIN}.
- Single module; the output buffer is inline, not a separate sub-module.
- The GRF read port is external: the top level muxes a spare port or a dedicated third read port to `rd_addr` and `rd_data`.

## Test plan
- Reset, GRF preloaded with $k = 0x1000_0000+k, `out_ready`=1, pulse `start` → 32 beats; beat k = ($k, 0x1000_0000+k) for k≥1 and beat 0 = (0, 0); `done` at T+34.
- `out_ready` low for 5 cycles mid-stream at beat 7 → beat 7 held stable for 5 cycles; no loss or duplication; `done` is delayed by 5 cycles.
- `SKIP_ZERO`=1, only $3=0xDEAD and $29=0x0000_2FFC nonzero → exactly 2 beats, (3, DEAD) then (29, 2FFC), then `done`.
- GRF write to $5 in the cycle after $5 is captured → beat 5 carries the old value; a write to $6 before its capture is reflected.
- `start` pulsed while `busy`, and `rst` driven low mid-dump → the second `start` has no effect; the reset clears all outputs asynchronously, no `done` is produced, and a fresh `start` restarts from address 0.
